// File: rtl/decrypt_feeder_if.sv
// rtl/decrypt_feeder_if.sv - byte-in / block-out stream bundle for decrypt_feeder
//
// Groups the two valid/ready streams around the feeder.
//   in_data/in_valid/in_ready    : upstream byte stream (key bytes, then ciphertext bytes, MSB first)
//   out_data/out_valid/out_ready : downstream plaintext blocks
// Modports:
//   master : the surrounding system (drives bytes in, consumes blocks out)
//   slave  : the feeder itself
interface decrypt_feeder_if #(
    parameter int BLOCK_W = 64
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/decrypt_feeder.sv
// rtl/decrypt_feeder.sv - byte-stream front-end that loads, launches and drains the Decrypt core
//
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset
//   bus            : decrypt_feeder_if.slave (byte stream in, plaintext block out)
//   dec_key        : key operand to the core
//   dec_ciphertext : ciphertext operand to the core
//   dec_reset      : core reset; high holds the core idle
//   dec_done       : core finished flag
//   dec_plaintext  : core result
//   timeout_err    : sticky watchdog flag (only when DEC_TIMEOUT_EN is defined)
// Optional feature macro: DEC_TIMEOUT_EN (RUN watchdog of MAX_CYCLES cycles).
module decrypt_feeder #(
    parameter int BLOCK_W    = 64,
    parameter int KEY_W      = 80,
    parameter int MAX_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    decrypt_feeder_if.slave    bus,
    output logic [KEY_W-1:0]   dec_key,
    output logic [BLOCK_W-1:0] dec_ciphertext,
    output logic               dec_reset,
    input  logic               dec_done,
    input  logic [BLOCK_W-1:0] dec_plaintext
`ifdef DEC_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);
    localparam int OP_W = KEY_W + BLOCK_W;
    localparam int N    = OP_W / 8;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;

    if ((BLOCK_W % 8) != 0 || (KEY_W % 8) != 0 || MAX_CYCLES < 1) begin : g_bad_params
        $error("decrypt_feeder: BLOCK_W/KEY_W must be multiples of 8 and MAX_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_LOAD,
        S_LAUNCH,
        S_RUN,
        S_OUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      byte_cnt;
    logic [OP_W-1:0]    opnd;        // {key, ciphertext}
    logic [OP_W-1:0]    opnd_nxt;
    logic               blk_full;    // a complete next block is parked while OUT drains
    logic [BLOCK_W-1:0] out_data_q;
    logic               accept;
    logic               last_byte;
    logic               timeout_hit;

    assign accept    = bus.in_valid & bus.in_ready;
    assign last_byte = accept & (byte_cnt == CW'(N - 1));

    assign dec_key        = opnd[OP_W-1 -: KEY_W];
    assign dec_ciphertext = opnd[BLOCK_W-1:0];
    assign bus.out_data   = out_data_q;

`ifdef DEC_TIMEOUT_EN
    localparam int TW = $clog2(MAX_CYCLES + 1);
    logic [TW-1:0] run_cnt;

    // Done on the same edge as the limit wins: the block completed in time.
    assign timeout_hit = (state == S_RUN) & ~dec_done & (run_cnt == TW'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            // LAUNCH always precedes RUN, so clearing here clears on RUN entry.
            if (state == S_LAUNCH) begin
                run_cnt <= '0;
            end else if (state == S_RUN) begin
                run_cnt <= run_cnt + TW'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Byte k goes to its fixed slot so partially loaded operands are well defined.
    always_comb begin
        opnd_nxt = opnd;
        for (int k = 0; k < N; k++) begin
            if (byte_cnt == CW'(k)) begin
                opnd_nxt[OP_W-1-8*k -: 8] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (last_byte) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (dec_done) begin
                    state_nxt = S_OUT;
                end else if (timeout_hit) begin
                    state_nxt = S_LOAD;
                end
            end
            S_OUT: begin
                // out_valid is always set in OUT, so out_ready alone drains it.
                if (bus.out_ready) begin
                    state_nxt = (blk_full | last_byte) ? S_LAUNCH : S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        dec_reset     = 1'b1;
        case (state)
            S_LOAD: begin
                bus.in_ready = 1'b1;
            end
            S_LAUNCH: begin
                bus.in_ready = 1'b0;
            end
            S_RUN: begin
                dec_reset = 1'b0;
            end
            S_OUT: begin
                bus.in_ready  = ~blk_full;
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            opnd       <= '0;
            blk_full   <= 1'b0;
            out_data_q <= '0;
        end else begin
            if (accept) begin
                opnd     <= opnd_nxt;
                byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
            end
            if (state == S_RUN && dec_done) begin
                out_data_q <= dec_plaintext;
            end
            if (state == S_OUT) begin
                blk_full <= bus.out_ready ? 1'b0 : (blk_full | last_byte);
            end else begin
                blk_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decrypt_feeder.sv
// tb/tb_decrypt_feeder.sv - self-checking bench for decrypt_feeder with a behavioural core and sink
module tb_decrypt_feeder;
    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int OP_W    = KEY_W + BLOCK_W;
    localparam int N       = OP_W / 8;

    typedef logic [7:0] byte_q_t[$];

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [KEY_W-1:0]   dec_key;
    logic [BLOCK_W-1:0] dec_ciphertext;
    logic [BLOCK_W-1:0] dec_plaintext;
    logic               dec_reset;
    logic               dec_done;
`ifdef DEC_TIMEOUT_EN
    logic               timeout_err;
`endif

    decrypt_feeder_if #(.BLOCK_W(BLOCK_W)) bus ();

    decrypt_feeder #(
        .BLOCK_W   (BLOCK_W),
        .KEY_W     (KEY_W),
        .MAX_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dec_key       (dec_key),
        .dec_ciphertext(dec_ciphertext),
        .dec_reset     (dec_reset),
        .dec_done      (dec_done),
        .dec_plaintext (dec_plaintext)
`ifdef DEC_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bit          core_en = 1'b1;
    int          core_lat = 5;
    logic [63:0] pt_next = 64'h0;
    bit          rnd_mode = 1'b0;
    logic [63:0] pt_q[$];
    logic [OP_W-1:0] op_q[$];
    int          consumed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference operand: the byte stream read as one big-endian number.
    function automatic logic [OP_W-1:0] pack(input byte_q_t b);
        logic [OP_W-1:0] v = '0;
        foreach (b[i]) v = (v << 8) | OP_W'(b[i]);
        return v;
    endfunction

    function automatic byte_q_t rand_block();
        byte_q_t b;
        for (int i = 0; i < N; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            $display("FAIL send_byte_wait: in_ready stayed %b, required 1 within 200 cycles", bus.in_ready);
            errors++;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input byte_q_t b, input bit gaps);
        foreach (b[i]) send_byte(b[i], gaps);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            $display("FAIL wait_out: out_valid stayed %b, required 1 within 100 cycles", bus.out_valid);
            errors++;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Behavioural Decrypt core: finishes core_lat cycles after release.
    initial begin : core_model
        int crun;
        logic [OP_W-1:0] exp_op;
        crun          = 0;
        dec_done      = 1'b0;
        dec_plaintext = '0;
        forever begin
            @(posedge clk);
            #1;
            dec_done      = 1'b0;
            dec_plaintext = {$urandom, $urandom};
            if (!core_en || dec_reset) begin
                crun = 0;
            end else begin
                crun++;
                if (crun == core_lat) begin
                    dec_done      = 1'b1;
                    dec_plaintext = pt_next;
                    if (rnd_mode) begin
                        checks++;
                        if (op_q.size() == 0) begin
                            $display("FAIL core_operands: core ran with no block expected");
                            errors++;
                        end else begin
                            exp_op = op_q.pop_front();
                            if ({dec_key, dec_ciphertext} !== exp_op) begin
                                $display("FAIL core_operands: got %h required %h", {dec_key, dec_ciphertext}, exp_op);
                                errors++;
                            end
                        end
                        pt_q.push_back(pt_next);
                        pt_next  = {$urandom, $urandom};
                        core_lat = $urandom_range(1, 8);
                    end
                end
            end
        end
    end

    // Random-ready downstream sink, active only in the randomized test.
    initial begin : sink_model
        logic [63:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (pt_q.size() == 0) begin
                        $display("FAIL sink_data: block offered with none expected, got %h", bus.out_data);
                        errors++;
                    end else begin
                        e = pt_q.pop_front();
                        if (bus.out_data !== e) begin
                            $display("FAIL sink_data: got %h required %h", bus.out_data, e);
                            errors++;
                        end
                    end
                    consumed++;
                end
            end
        end
    end

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); errors++; end
        checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); errors++; end
        checks++; if (bus.out_data !== 64'h0) begin $display("FAIL reset_out_data: got %h required 0", bus.out_data); errors++; end
        checks++; if (dec_key !== 80'h0) begin $display("FAIL reset_dec_key: got %h required 0", dec_key); errors++; end
        checks++; if (dec_ciphertext !== 64'h0) begin $display("FAIL reset_dec_ct: got %h required 0", dec_ciphertext); errors++; end
        checks++; if (dec_reset !== 1'b1) begin $display("FAIL reset_dec_reset: got %b required 1", dec_reset); errors++; end
`ifdef DEC_TIMEOUT_EN
        checks++; if (timeout_err !== 1'b0) begin $display("FAIL reset_timeout_err: got %b required 0", timeout_err); errors++; end
`endif
        bus.in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        byte_q_t b;
        int n;
        do_reset();
        bus.out_ready = 1'b1;
        core_lat = 5;
        pt_next  = 64'hDEADBEEFCAFEF00D;
        for (int i = 0; i < N; i++) b.push_back(8'(i));
        send_block(b, 1'b0);
        checks++; if (dec_key !== 80'h00010203040506070809) begin $display("FAIL basic_key: got %h required 00010203040506070809", dec_key); errors++; end
        checks++; if (dec_ciphertext !== 64'h0A0B0C0D0E0F1011) begin $display("FAIL basic_ct: got %h required 0a0b0c0d0e0f1011", dec_ciphertext); errors++; end
        checks++; if (dec_reset !== 1'b1 || bus.in_ready !== 1'b0) begin $display("FAIL basic_launch: dec_reset=%b in_ready=%b required 1/0", dec_reset, bus.in_ready); errors++; end
        tick();
        checks++; if (dec_reset !== 1'b0) begin $display("FAIL basic_release: dec_reset got %b required 0", dec_reset); errors++; end
        wait_out(n);
        checks++; if (n !== 5) begin $display("FAIL basic_latency: got %0d cycles required 5", n); errors++; end
        checks++; if (bus.out_data !== 64'hDEADBEEFCAFEF00D) begin $display("FAIL basic_out_data: got %h required deadbeefcafef00d", bus.out_data); errors++; end
        checks++; if (dec_reset !== 1'b1) begin $display("FAIL basic_rehold: dec_reset got %b required 1", dec_reset); errors++; end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL basic_one_cycle: out_valid got %b required 0", bus.out_valid); errors++; end
        checks++; if (bus.in_ready !== 1'b1) begin $display("FAIL basic_back_to_load: in_ready got %b required 1", bus.in_ready); errors++; end
    endtask

    task automatic test_overlap();
        byte_q_t a, b;
        logic [63:0] p1, p2;
        int n;
        do_reset();
        core_lat = 3;
        p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        a = rand_block();
        b = rand_block();
        pt_next = p1;
        send_block(a, 1'b0);
        wait_out(n);
        checks++; if (bus.out_data !== p1) begin $display("FAIL overlap_first: got %h required %h", bus.out_data, p1); errors++; end
        pt_next = p2;
        send_block(b, 1'b0);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin $display("FAIL overlap_park: in_ready=%b out_valid=%b required 0/1", bus.in_ready, bus.out_valid); errors++; end
        checks++; if ({dec_key, dec_ciphertext} !== pack(b)) begin $display("FAIL overlap_ops: got %h required %h", {dec_key, dec_ciphertext}, pack(b)); errors++; end
        repeat (3) tick();
        checks++; if (bus.out_data !== p1 || bus.out_valid !== 1'b1) begin $display("FAIL overlap_hold: out_data=%h valid=%b required %h/1", bus.out_data, bus.out_valid, p1); errors++; end
        checks++; if (dec_reset !== 1'b1 || bus.in_ready !== 1'b0) begin $display("FAIL overlap_wait: dec_reset=%b in_ready=%b required 1/0", dec_reset, bus.in_ready); errors++; end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || dec_reset !== 1'b1) begin $display("FAIL overlap_drain: out_valid=%b dec_reset=%b required 0/1", bus.out_valid, dec_reset); errors++; end
        tick();
        checks++; if (dec_reset !== 1'b0) begin $display("FAIL overlap_launch: dec_reset got %b required 0", dec_reset); errors++; end
        wait_out(n);
        checks++; if (bus.out_data !== p2) begin $display("FAIL overlap_second: got %h required %h", bus.out_data, p2); errors++; end
        tick();
    endtask

    task automatic test_simultaneous();
        byte_q_t a, b, c;
        logic [63:0] p2, p3;
        int n;
        do_reset();
        core_lat = 2;
        a = rand_block();
        b = rand_block();
        c = rand_block();
        pt_next = {$urandom, $urandom};
        send_block(a, 1'b0);
        wait_out(n);
        p2 = {$urandom, $urandom};
        pt_next = p2;
        for (int i = 0; i < N - 1; i++) send_byte(b[i], 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = b[N-1];
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dec_reset !== 1'b1) begin $display("FAIL simul_launch: out_valid=%b in_ready=%b dec_reset=%b required 0/0/1", bus.out_valid, bus.in_ready, dec_reset); errors++; end
        checks++; if ({dec_key, dec_ciphertext} !== pack(b)) begin $display("FAIL simul_ops: got %h required %h", {dec_key, dec_ciphertext}, pack(b)); errors++; end
        tick();
        checks++; if (dec_reset !== 1'b0) begin $display("FAIL simul_release: dec_reset got %b required 0", dec_reset); errors++; end
        bus.out_ready = 1'b0;
        wait_out(n);
        checks++; if (bus.out_data !== p2) begin $display("FAIL simul_data: got %h required %h", bus.out_data, p2); errors++; end
        p3 = {$urandom, $urandom};
        pt_next = p3;
        for (int i = 0; i < 5; i++) send_byte(c[i], 1'b0);
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dec_reset !== 1'b1) begin $display("FAIL partial_to_load: out_valid=%b in_ready=%b dec_reset=%b required 0/1/1", bus.out_valid, bus.in_ready, dec_reset); errors++; end
        for (int i = 5; i < N; i++) send_byte(c[i], 1'b0);
        checks++; if ({dec_key, dec_ciphertext} !== pack(c)) begin $display("FAIL partial_ops: got %h required %h", {dec_key, dec_ciphertext}, pack(c)); errors++; end
        wait_out(n);
        checks++; if (bus.out_data !== p3) begin $display("FAIL partial_data: got %h required %h", bus.out_data, p3); errors++; end
        tick();
    endtask

    task automatic test_reset_midop();
        byte_q_t junk, d;
        logic [63:0] p;
        int n;
        do_reset();
        bus.out_ready = 1'b1;
        core_lat = 4;
        junk = rand_block();
        d = rand_block();
        for (int i = 0; i < 7; i++) send_byte(junk[i], 1'b0);
        rst = 1'b1;
        tick();
        checks++; if ({dec_key, dec_ciphertext} !== '0) begin $display("FAIL midop_clear: got %h required 0", {dec_key, dec_ciphertext}); errors++; end
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin $display("FAIL midop_state: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); errors++; end
        rst = 1'b0;
        tick();
        p = {$urandom, $urandom};
        pt_next = p;
        for (int i = 0; i < N - 1; i++) send_byte(d[i], 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || dec_reset !== 1'b1) begin $display("FAIL midop_spurious: out_valid=%b dec_reset=%b required 0/1", bus.out_valid, dec_reset); errors++; end
        send_byte(d[N-1], 1'b0);
        checks++; if ({dec_key, dec_ciphertext} !== pack(d)) begin $display("FAIL midop_ops: got %h required %h", {dec_key, dec_ciphertext}, pack(d)); errors++; end
        wait_out(n);
        checks++; if (bus.out_data !== p) begin $display("FAIL midop_data: got %h required %h", bus.out_data, p); errors++; end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL midop_single: out_valid got %b required 0", bus.out_valid); errors++; end
    endtask

    task automatic test_gaps();
        byte_q_t b;
        int n;
        do_reset();
        bus.out_ready = 1'b1;
        core_lat = 3;
        pt_next = 64'h0123456789ABCDEF;
        for (int i = 0; i < N; i++) b.push_back(8'(i));
        send_block(b, 1'b1);
        checks++; if (dec_key !== 80'h00010203040506070809 || dec_ciphertext !== 64'h0A0B0C0D0E0F1011) begin $display("FAIL gaps_ops: got %h_%h required 00010203040506070809_0a0b0c0d0e0f1011", dec_key, dec_ciphertext); errors++; end
        wait_out(n);
        checks++; if (bus.out_data !== 64'h0123456789ABCDEF) begin $display("FAIL gaps_data: got %h required 0123456789abcdef", bus.out_data); errors++; end
        tick();
    endtask

    task automatic test_back_to_back();
        byte_q_t b;
        int n;
        do_reset();
        pt_q.delete();
        op_q.delete();
        consumed = 0;
        core_lat = $urandom_range(1, 8);
        pt_next  = {$urandom, $urandom};
        rnd_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b = rand_block();
            send_block(b, 1'(($urandom & 1)));
            op_q.push_back(pack(b));
        end
        n = 0;
        while (consumed < 8 && n < 1000) begin
            tick();
            n++;
        end
        rnd_mode = 1'b0;
        checks++; if (consumed !== 8) begin $display("FAIL b2b_count: consumed %0d blocks required 8", consumed); errors++; end
        checks++; if (pt_q.size() !== 0 || op_q.size() !== 0) begin $display("FAIL b2b_leftover: pt_q=%0d op_q=%0d required 0/0", pt_q.size(), op_q.size()); errors++; end
        bus.out_ready = 1'b0;
        tick();
    endtask

`ifdef DEC_TIMEOUT_EN
    task automatic test_timeout();
        byte_q_t b;
        do_reset();
        core_en = 1'b0;
        bus.out_ready = 1'b1;
        b = rand_block();
        send_block(b, 1'b0);
        tick();
        checks++; if (dec_reset !== 1'b0) begin $display("FAIL to_release: dec_reset got %b required 0", dec_reset); errors++; end
        repeat (15) tick();
        checks++; if (timeout_err !== 1'b0 || dec_reset !== 1'b0) begin $display("FAIL to_early: timeout_err=%b dec_reset=%b required 0/0", timeout_err, dec_reset); errors++; end
        tick();
        checks++; if (timeout_err !== 1'b1 || dec_reset !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin $display("FAIL to_fire: err=%b dec_reset=%b in_ready=%b out_valid=%b required 1/1/1/0", timeout_err, dec_reset, bus.in_ready, bus.out_valid); errors++; end
        repeat (5) tick();
        checks++; if (timeout_err !== 1'b1 || bus.out_valid !== 1'b0) begin $display("FAIL to_sticky: err=%b out_valid=%b required 1/0", timeout_err, bus.out_valid); errors++; end
        do_reset();
        checks++; if (timeout_err !== 1'b0) begin $display("FAIL to_clear: got %b required 0", timeout_err); errors++; end
        core_en = 1'b1;
    endtask
`endif

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_simultaneous();
        test_reset_midop();
        test_gaps();
        test_back_to_back();
`ifdef DEC_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
